// File: rtl/pe_inject_arbiter_if.sv
// Injection-channel bundle: requester flit/valid/ready plus the router-side
// flit, valid and credit return.
interface pe_inject_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [20*N_REQ-1:0] req_flit;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic                ci;
  logic [19:0]         dataout;
  logic                out_valid;

  modport master (
    output req_flit, req_valid, ci,
    input  req_ready, dataout, out_valid
  );

  modport slave (
    input  req_flit, req_valid, ci,
    output req_ready, dataout, out_valid
  );
endinterface

// File: rtl/pe_inject_arbiter.sv
// Round-robin arbiter with packet locking that shares one router injection
// port among N_REQ sources, gated by downstream buffer credits.
module pe_inject_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3
) (
  input  logic                clk,
  input  logic                RST,
  pe_inject_arbiter_if.slave  bus,
  output logic [CW-1:0]       credit_cnt,
  output logic                locked,
  output logic [2:0]          owner,
  output logic                err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]     owner_q, owner_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [19:0]    dout_q, dout_d;
  logic           ov_q, ov_d;
  logic           err_q, err_d;

  logic             found;
  logic [2:0]       win;
  logic [2:0]       gidx;
  logic [N_REQ-1:0] ready;
  logic             send;
  logic [19:0]      flit;
  logic [1:0]       ftype;

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // Ready is masked during reset so no requester sees a grant while RST is low.
  always_comb begin
    gidx  = (state_q == LOCKED) ? owner_q : win;
    ready = '0;
    flit  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx == 3'(i)) begin
        ready[i] = RST && (credit_q != '0) && ((state_q == LOCKED) || found);
        flit     = bus.req_flit[20*i +: 20];
      end
    end
  end

  assign send  = |(ready & bus.req_valid);
  assign ftype = flit[19:18];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    err_d    = err_q;
    ov_d     = send;
    dout_d   = send ? flit : dout_q;

    if (send) begin
      if (state_q == IDLE) begin
        rr_ptr_d = (gidx == 3'(N_REQ - 1)) ? '0 : gidx + 3'd1;
        if (ftype == 2'b01) begin
          state_d = LOCKED;
          owner_d = gidx;
        end else if (ftype[1]) begin
          err_d = 1'b1;
        end
      end else begin
        if (ftype == 2'b11) begin
          state_d = IDLE;
          owner_d = '0;
        end else if (!ftype[1]) begin
          err_d = 1'b1;
        end
      end
    end

    case ({send, bus.ci})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CW'(CREDITS)) err_d = 1'b1;
        else                          credit_d = credit_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      credit_q <= CW'(CREDITS);
      dout_q   <= '0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      dout_q   <= dout_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.dataout   = dout_q;
  assign bus.out_valid = ov_q;
  assign credit_cnt    = credit_q;
  assign locked        = (state_q == LOCKED);
  assign owner         = owner_q;
  assign err           = err_q;

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Bench for pe_inject_arbiter: directed scenarios followed by random well-formed
// packet traffic, all checked against a cycle-level behavioural model.
module tb_pe_inject_arbiter;
  localparam int N  = 4;
  localparam int CR = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] credit_cnt;
  logic       locked;
  logic [2:0] owner;
  logic       err;

  always #5 clk = ~clk;

  pe_inject_arbiter_if #(.N_REQ(N)) bus ();

  pe_inject_arbiter #(.N_REQ(N), .CREDITS(CR), .CW(3)) dut (
    .clk        (clk),
    .RST        (rst_n),
    .bus        (bus),
    .credit_cnt (credit_cnt),
    .locked     (locked),
    .owner      (owner),
    .err        (err)
  );

  int          total, bad;
  int          m_credits, m_rr, m_owner, acc_w, n_acc;
  bit          m_locked, m_err, m_ov, known;
  logic [19:0] m_dout;
  logic [19:0] flit_a [N];
  bit          in_pkt [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who may send this cycle, from the channel rules alone.
  function automatic logic [N-1:0] model_ready(input logic r, input logic [N-1:0] v);
    logic [N-1:0] res;
    int           i;
    res = '0;
    if (!r || m_credits == 0) return res;
    if (m_locked) begin
      for (int j = 0; j < N; j++) if (j == m_owner) res[j] = 1'b1;
      return res;
    end
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (v[i]) begin
        res[i] = 1'b1;
        return res;
      end
    end
    return res;
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] v, input logic c);
    logic [N-1:0] er;
    logic [1:0]   t;
    if (known) begin
      chk("out_valid",  32'(bus.out_valid), 32'(m_ov));
      chk("dataout",    32'(bus.dataout),   32'(m_dout));
      chk("credit_cnt", 32'(credit_cnt),    32'(m_credits));
      chk("locked",     32'(locked),        32'(m_locked));
      chk("owner",      32'(owner),         32'(m_owner));
      chk("err",        32'(err),           32'(m_err));
    end
    rst_n         = r;
    bus.req_valid = v;
    bus.ci        = c;
    for (int i = 0; i < N; i++) bus.req_flit[20*i +: 20] = flit_a[i];
    #1;
    er = model_ready(r, v);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    acc_w = -1;
    if (!r) begin
      m_credits = CR; m_rr = 0; m_owner = 0; m_locked = 0;
      m_err = 0; m_ov = 0; m_dout = '0; known = 1;
    end else begin
      m_ov = 0;
      for (int i = 0; i < N; i++) if (er[i] && v[i]) acc_w = i;
      if (acc_w >= 0) begin
        t = flit_a[acc_w][19:18];
        m_ov = 1;
        m_dout = flit_a[acc_w];
        m_credits--;
        if (!m_locked) begin
          m_rr = (acc_w + 1) % N;
          if (t == 2'b01) begin m_locked = 1; m_owner = acc_w; end
          else if (t[1]) m_err = 1;
        end else begin
          if (t == 2'b11) begin m_locked = 0; m_owner = 0; end
          else if (!t[1]) m_err = 1;
        end
      end
      if (c) begin
        m_credits++;
        if (m_credits > CR) begin m_credits = CR; m_err = 1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] new_flit(input bit mid);
    logic [1:0] t;
    if (mid) t = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    else     t = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b01;
    return {t, 18'($urandom)};
  endfunction

  initial begin
    total = 0; bad = 0; known = 0;
    rst_n = 1'b0; bus.ci = 1'b0; bus.req_valid = '0; bus.req_flit = '0;
    for (int i = 0; i < N; i++) flit_a[i] = 20'h00010 + 20'(i);

    // reset with all requesters asking
    cycle(0, '1, 0);
    cycle(0, '1, 0);
    chk("rst_credit", 32'(credit_cnt),    32'd4);
    chk("rst_ov",     32'(bus.out_valid), 32'd0);
    chk("rst_dout",   32'(bus.dataout),   32'd0);
    chk("rst_ready",  32'(bus.req_ready), 32'd0);

    // round-robin singles 0,1,2,3,0 with continuous credit return
    for (int i = 0; i < 5; i++) begin
      cycle(1, '1, (i != 0));
      chk("rr_dout", 32'(bus.dataout),   32'h10 + 32'(i % 4));
      chk("rr_ov",   32'(bus.out_valid), 32'd1);
    end
    chk("rr_credit", 32'(credit_cnt), 32'd3);

    // packet lock on req1 while req2 waits
    flit_a[1] = 20'h40001; flit_a[2] = 20'h00077;
    cycle(1, 4'b0110, 1);
    chk("lock_on",    32'(locked), 32'd1);
    chk("lock_owner", 32'(owner),  32'd1);
    flit_a[1] = 20'h80002;
    cycle(1, 4'b0110, 1);
    chk("lock_body", 32'(bus.dataout), 32'h80002);
    flit_a[1] = 20'hC0003;
    cycle(1, 4'b0110, 1);
    chk("lock_tail", 32'(bus.dataout), 32'hC0003);
    chk("lock_off",  32'(locked),      32'd0);
    cycle(1, 4'b0100, 1);
    chk("lock_next", 32'(bus.dataout), 32'h00077);

    // credit exhaustion
    cycle(1, 4'b0000, 1);
    chk("full_credit", 32'(credit_cnt), 32'd4);
    flit_a[0] = 20'h00100;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 4'b0001, 0);
      n_acc += int'(bus.out_valid);
    end
    chk("exh_accepts", 32'(n_acc),          32'd4);
    chk("exh_credit",  32'(credit_cnt),     32'd0);
    chk("exh_ready",   32'(bus.req_ready),  32'd0);
    cycle(1, 4'b0001, 1);
    chk("exh_ci",      32'(credit_cnt),     32'd1);
    chk("exh_ci_ov",   32'(bus.out_valid),  32'd0);
    cycle(1, 4'b0001, 0);
    chk("exh_last_ov", 32'(bus.out_valid),  32'd1);
    chk("exh_last_cr", 32'(credit_cnt),     32'd0);

    // simultaneous send and credit return, then overflow
    cycle(1, 4'b0000, 1);
    cycle(1, 4'b0000, 1);
    chk("sc_pre", 32'(credit_cnt), 32'd2);
    cycle(1, 4'b0001, 1);
    chk("sc_hold", 32'(credit_cnt),    32'd2);
    chk("sc_ov",   32'(bus.out_valid), 32'd1);
    cycle(1, 4'b0000, 1);
    cycle(1, 4'b0000, 1);
    chk("ovf_pre_err", 32'(err), 32'd0);
    cycle(1, 4'b0000, 1);
    chk("ovf_credit", 32'(credit_cnt), 32'd4);
    chk("ovf_err",    32'(err),        32'd1);

    // body flit while idle
    cycle(0, 4'b0000, 0);
    flit_a[3] = 20'h80005;
    cycle(1, 4'b1000, 0);
    chk("perr_dout",   32'(bus.dataout),   32'h80005);
    chk("perr_ov",     32'(bus.out_valid), 32'd1);
    chk("perr_locked", 32'(locked),        32'd0);
    chk("perr_err",    32'(err),           32'd1);

    // reset while a packet holds the channel
    flit_a[0] = 20'h40009;
    cycle(1, 4'b0001, 0);
    chk("mid_locked", 32'(locked), 32'd1);
    cycle(0, 4'b0001, 0);
    chk("mid_rst_locked", 32'(locked),        32'd0);
    chk("mid_rst_credit", 32'(credit_cnt),    32'd4);
    chk("mid_rst_err",    32'(err),           32'd0);
    chk("mid_rst_ov",     32'(bus.out_valid), 32'd0);

    // random well-formed packet traffic with a router that never overflows
    for (int i = 0; i < N; i++) begin
      in_pkt[i] = 0;
      flit_a[i] = new_flit(0);
    end
    for (int n = 0; n < 2000; n++) begin
      cycle(1, N'($urandom), (m_credits < CR) && ($urandom_range(0, 2) != 0));
      if (acc_w >= 0) begin
        in_pkt[acc_w] = (flit_a[acc_w][19:18] == 2'b01) || (flit_a[acc_w][19:18] == 2'b10);
        flit_a[acc_w] = new_flit(in_pkt[acc_w]);
      end
    end
    chk("rand_err", 32'(err), 32'd0);
    cycle(1, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_inject_arbiter.md
Name: pe_inject_arbiter

Overview:
- Shares a node's single local injection channel (router port 5: 20-bit flit, valid, credit return) among N_REQ traffic sources inside a processing element.
- Arbitration is round-robin with packet locking: once a head flit wins, that requester keeps the channel until its tail flit is sent.
- Tracks downstream buffer credits and never issues a flit without a credit.
- The output is registered and drives the router's in5/vi5 directly; co5 feeds ci.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CREDITS, 4, router input-buffer depth; initial and maximum credit count.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous active-low reset.
- req_flit  input  20*N_REQ  requester i flit on bits [20*i+19:20*i].
- req_valid  input  N_REQ  per-requester flit valid.
- req_ready  output  N_REQ  per-requester accept (combinational); a flit transfers when valid&&ready.
- ci  input  1  credit return pulse from router; one credit per cycle high.
- dataout  output  20  flit to router in5.
- out_valid  output  1  flit valid to router vi5.
- credit_cnt  output  CW  current credits available.
- locked  output  1  high while a multi-flit packet owns the channel.
- owner  output  3  index of locked requester (0 when unlocked).
- err  output  1  sticky protocol/credit error flag.

Behaviour:
- Flit type is flit[19:18]:
  - 00 = single (head+tail)
  - 01 = head
  - 10 = body
  - 11 = tail
- Reset: when RST is low at a clk edge:
  - state=IDLE, rr_ptr=0, owner=0, locked=0
  - credit_cnt=CREDITS
  - dataout=0, out_valid=0, err=0
- Reset mid-packet discards the lock; no flit is emitted the cycle after reset.
- States: IDLE (no owner), LOCKED (owner fixed).
- IDLE grant: the winner is the first i with req_valid[i]=1, scanning from rr_ptr upward modulo N_REQ.
  - req_ready[winner]=1 iff credit_cnt!=0; all other ready bits are 0.
  - If no requester is valid, all ready bits are 0.
- LOCKED grant: req_ready[owner]=1 iff credit_cnt!=0; all other ready bits are 0, regardless of their valid.
- At most one req_ready bit is high in any cycle. Ready does not depend on the current cycle's ci.
- On a transfer from requester w:
  - IDLE, type 01: go to LOCKED, owner=w, rr_ptr=(w+1) mod N_REQ.
  - IDLE, type 00: stay IDLE, rr_ptr=(w+1) mod N_REQ.
  - IDLE, type 10 or 11: forward the flit, stay IDLE, advance rr_ptr, set err.
  - LOCKED, type 10: stay LOCKED.
  - LOCKED, type 11: go to IDLE, owner=0.
  - LOCKED, type 01 or 00 from owner: forward the flit, stay LOCKED, set err.
- Output timing: on a transfer cycle, dataout<=flit and out_valid<=1 at the next edge, so latency is exactly 1 cycle.
  - On a non-transfer cycle, out_valid<=0 and dataout holds its last value.
  - Back-to-back transfers give continuous out_valid.
- Credits: credit_cnt_next = credit_cnt - send + ci, where send is the transfer this cycle.
  - Simultaneous send and ci leaves the count unchanged.
  - A credit returned this cycle is usable next cycle.
  - If credit_cnt==CREDITS, ci=1 and send=0: hold at CREDITS and set err (overflow).
  - Underflow cannot occur because ready is gated by credit_cnt!=0.
- Credit exhaustion mid-packet: the lock is held, the owner stalls, and no other requester is granted.
- err clears only on reset.

Test Plan:
- Reset: hold RST=0 for 2 cycles with all valids high → out_valid=0, dataout=0, credit_cnt=4, req_ready=0000 during reset; 1 cycle after release, req_ready=0001.
- Round-robin singles: all four requesters present type-00 flits continuously, ci pulsed every cycle after the first → grants in order 0,1,2,3,0; out_valid high continuously; dataout follows the accepted flits one cycle later; credit_cnt ends steady at 3.
- Packet lock: req1 sends head/body/tail (0x4_0001, 0x8_0002, 0xC_0003) while req2 holds valid single 0x0_0077 → req2 ready stays 0 until the cycle after the tail is accepted; locked=1, owner=1 during the packet; req2 is granted next.
- Credit exhaustion: no ci, req0 streams 6 singles → exactly 4 accepted, credit_cnt=0, req_ready=0; one ci pulse → credit_cnt=1 next cycle, one more flit accepted, credit_cnt=0.
- Simultaneous send+ci with credit_cnt=2 → credit_cnt stays 2. With credit_cnt=4, idle, ci=1 → credit_cnt=4, err=1.
- Protocol error: a body flit 0x8_0005 from req3 while IDLE → forwarded 1 cycle later, state IDLE, err=1. Reset mid-LOCKED → locked=0, credit_cnt=4, err=0.
